// File: rtl/level_limiter_pkg.sv
// Shared constants and limit-value helper for the level limiter.
package level_limiter_pkg;

   localparam int CLIP_COUNT_WIDTH = 32;

   // Returns MAX (want_min=0) or MIN (want_min=1) of a limit_bits signed range,
   // two's-complement encoded in the low data_width bits.
   function automatic logic [31:0] limit_value(input int data_width, input int limit_bits,
                                               input logic want_min);
      logic [63:0] full;
      logic [63:0] mask;
      full = 64'd1 << (limit_bits - 1);
      full = want_min ? (~full + 64'd1) : (full - 64'd1);
      mask = (64'd1 << data_width) - 64'd1;
      return 32'(full & mask);
   endfunction

endpackage

// File: rtl/level_limiter_sat.sv
// Combinational signed saturator: clamps a sample to LIMIT_NUMBER_OF_BITS signed range.
module level_limiter_sat
   import level_limiter_pkg::*;
#(
   parameter int DATA_WIDTH           = 24,
   parameter int LIMIT_NUMBER_OF_BITS = 16
) (
   input  logic signed [DATA_WIDTH-1:0] sample,
   output logic signed [DATA_WIDTH-1:0] limited,
   output logic                         clip_pos,
   output logic                         clip_neg
);

   generate
      if (LIMIT_NUMBER_OF_BITS == DATA_WIDTH) begin : g_pass
         assign limited  = sample;
         assign clip_pos = 1'b0;
         assign clip_neg = 1'b0;
      end else begin : g_sat
         localparam logic [DATA_WIDTH-1:0] MAX_VAL =
            DATA_WIDTH'(limit_value(DATA_WIDTH, LIMIT_NUMBER_OF_BITS, 1'b0));
         localparam logic [DATA_WIDTH-1:0] MIN_VAL =
            DATA_WIDTH'(limit_value(DATA_WIDTH, LIMIT_NUMBER_OF_BITS, 1'b1));

         // In range exactly when the discarded bits all repeat the new sign bit.
         logic [DATA_WIDTH-LIMIT_NUMBER_OF_BITS:0] top_bits;
         logic                                     in_range;
         assign top_bits = sample[DATA_WIDTH-1:LIMIT_NUMBER_OF_BITS-1];
         assign in_range = (&top_bits) | ~(|top_bits);

         always_comb begin
            limited  = sample;
            clip_pos = 1'b0;
            clip_neg = 1'b0;
            if (!in_range) begin
               if (sample[DATA_WIDTH-1]) begin
                  limited  = MIN_VAL;
                  clip_neg = 1'b1;
               end else begin
                  limited  = MAX_VAL;
                  clip_pos = 1'b1;
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/level_limiter.sv
// Registered signed level limiter with clip flags.
// Optional saturating clip counter enabled by LEVEL_LIMITER_CLIP_COUNT_EN.
module level_limiter
   import level_limiter_pkg::*;
#(
   parameter int DATA_WIDTH           = 24,
   parameter int LIMIT_NUMBER_OF_BITS = 16
) (
   input  logic                               i_clk,
   input  logic                               i_reset,
   input  logic signed [DATA_WIDTH-1:0]       iS_data,
   input  logic                               i_valid,
`ifdef LEVEL_LIMITER_CLIP_COUNT_EN
   input  logic                               i_clip_count_clear,
   output logic [CLIP_COUNT_WIDTH-1:0]        o_clip_count,
`endif
   output logic signed [DATA_WIDTH-1:0]       oS_data,
   output logic                               o_valid,
   output logic                               o_clip_pos,
   output logic                               o_clip_neg
);

   generate
      if (DATA_WIDTH < 2 || DATA_WIDTH > 32 ||
          LIMIT_NUMBER_OF_BITS < 2 || LIMIT_NUMBER_OF_BITS > DATA_WIDTH) begin : g_bad_params
         $error("level_limiter: illegal DATA_WIDTH/LIMIT_NUMBER_OF_BITS combination");
      end
   endgenerate

   logic signed [DATA_WIDTH-1:0] sat_data;
   logic                         sat_pos;
   logic                         sat_neg;

   level_limiter_sat #(
      .DATA_WIDTH          (DATA_WIDTH),
      .LIMIT_NUMBER_OF_BITS(LIMIT_NUMBER_OF_BITS)
   ) u_sat (
      .sample  (iS_data),
      .limited (sat_data),
      .clip_pos(sat_pos),
      .clip_neg(sat_neg)
   );

   // Data and flags hold across invalid cycles; only o_valid tracks i_valid.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         oS_data    <= '0;
         o_valid    <= 1'b0;
         o_clip_pos <= 1'b0;
         o_clip_neg <= 1'b0;
      end else begin
         o_valid <= i_valid;
         if (i_valid) begin
            oS_data    <= sat_data;
            o_clip_pos <= sat_pos;
            o_clip_neg <= sat_neg;
         end
      end
   end

`ifdef LEVEL_LIMITER_CLIP_COUNT_EN
   logic [CLIP_COUNT_WIDTH-1:0] clip_count;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         clip_count <= '0;
      end else if (i_clip_count_clear) begin
         clip_count <= '0;
      end else if (i_valid && (sat_pos || sat_neg) && (clip_count != '1)) begin
         clip_count <= clip_count + 1'b1;
      end
   end

   assign o_clip_count = clip_count;
`endif

endmodule

// File: tb/tb_level_limiter.sv
// Self-checking bench for level_limiter: arithmetic reference model plus literal spot checks.
module tb_level_limiter;

   localparam int DW   = 24;
   localparam int LW   = 16;
   localparam int MAXI = (1 << (LW - 1)) - 1;
   localparam int MINI = -(1 << (LW - 1));
   localparam longint CNT_MAX = 64'd4294967295;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] din = '0;
   logic          vin = 1'b0;
   logic [DW-1:0] dout;
   logic          vout;
   logic          pos;
   logic          neg;
`ifdef LEVEL_LIMITER_CLIP_COUNT_EN
   logic          clr = 1'b0;
   logic [31:0]   cnt;
`endif

   level_limiter #(
      .DATA_WIDTH          (DW),
      .LIMIT_NUMBER_OF_BITS(LW)
   ) dut (
      .i_clk             (clk),
      .i_reset           (rst),
      .iS_data           (din),
      .i_valid           (vin),
`ifdef LEVEL_LIMITER_CLIP_COUNT_EN
      .i_clip_count_clear(clr),
      .o_clip_count      (cnt),
`endif
      .oS_data           (dout),
      .o_valid           (vout),
      .o_clip_pos        (pos),
      .o_clip_neg        (neg)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integer comparison against the signed limits.
   int     m_data  = 0;
   bit     m_valid = 1'b0;
   bit     m_pos   = 1'b0;
   bit     m_neg   = 1'b0;
   longint m_cnt   = 0;
   int     x;
   bit     clipped;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_data = 0; m_valid = 0; m_pos = 0; m_neg = 0; m_cnt = 0;
      end else begin
         x       = int'($signed(din));
         clipped = (x > MAXI) || (x < MINI);
         m_valid = vin;
         if (vin) begin
            m_pos  = (x > MAXI);
            m_neg  = (x < MINI);
            m_data = (x > MAXI) ? MAXI : (x < MINI) ? MINI : x;
         end
`ifdef LEVEL_LIMITER_CLIP_COUNT_EN
         if (clr) m_cnt = 0;
         else if (vin && clipped && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
`endif
      end
   end

   always @(negedge clk) begin
      if (check_en && !rst) begin
         check("valid", longint'(vout), longint'(m_valid));
         check("data", $signed(dout), longint'(m_data));
         check("clip_pos", longint'(pos), longint'(m_pos));
         check("clip_neg", longint'(neg), longint'(m_neg));
         check("flags_exclusive", longint'(pos & neg), 0);
`ifdef LEVEL_LIMITER_CLIP_COUNT_EN
         check("clip_count", longint'(cnt), m_cnt);
`endif
      end
   end

   task automatic step(input bit v, input logic [DW-1:0] d);
      vin = v;
      din = d;
      @(negedge clk);
   endtask

   task automatic expect_out(input string name, input int d, input bit p, input bit n);
      check({name, "_data"}, $signed(dout), longint'(d));
      check({name, "_pos"}, longint'(pos), longint'(p));
      check({name, "_neg"}, longint'(neg), longint'(n));
      check({name, "_valid"}, longint'(vout), 1);
   endtask

   task automatic expect_zero(input string name);
      check({name, "_data"}, $signed(dout), 0);
      check({name, "_valid"}, longint'(vout), 0);
      check({name, "_pos"}, longint'(pos), 0);
      check({name, "_neg"}, longint'(neg), 0);
`ifdef LEVEL_LIMITER_CLIP_COUNT_EN
      check({name, "_count"}, longint'(cnt), 0);
`endif
   endtask

   typedef struct { logic [DW-1:0] d; int e; bit p; bit n; } vec_t;
   vec_t vecs[7];

   initial begin
      vecs[0] = '{24'd32767,    32767, 1'b0, 1'b0};
      vecs[1] = '{24'd32768,    32767, 1'b1, 1'b0};
      vecs[2] = '{24'hFF8000,  -32768, 1'b0, 1'b0};
      vecs[3] = '{24'hFF7FFF,  -32768, 1'b0, 1'b1};
      vecs[4] = '{24'h7FFFFF,   32767, 1'b1, 1'b0};
      vecs[5] = '{24'h800000,  -32768, 1'b0, 1'b1};
      vecs[6] = '{24'h00FFFF,   32767, 1'b1, 1'b0};

      #1 expect_zero("reset_init");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_en = 1'b1;

      for (int i = 0; i <= 32800; i++) begin
         step(1'b1, DW'(i));
         if (i == 0)     expect_out("ramp_zero", 0, 1'b0, 1'b0);
         if (i == 32767) expect_out("ramp_max", 32767, 1'b0, 1'b0);
         if (i == 32768) expect_out("ramp_first_clip", 32767, 1'b1, 1'b0);
`ifdef LEVEL_LIMITER_CLIP_COUNT_EN
         if (i == 32780) check("ramp_count", longint'(cnt), 13);
`endif
         if (i == 32790) begin
            #2 rst = 1'b1;
            #1 expect_zero("reset_mid");
            #1 rst = 1'b0;
            step(1'b1, DW'(i + 1));
            expect_out("after_reset", 32767, 1'b1, 1'b0);
            i++;
         end
      end

      foreach (vecs[k]) begin
         step(1'b1, vecs[k].d);
         expect_out($sformatf("boundary%0d", k), vecs[k].e, vecs[k].p, vecs[k].n);
      end

      step(1'b1, DW'(100));
      expect_out("pre_gap", 100, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, DW'($urandom));
         check("gap_valid", longint'(vout), 0);
         check("gap_hold", $signed(dout), 100);
      end
      step(1'b1, DW'(5));
      expect_out("after_gap", 5, 1'b0, 1'b0);

`ifdef LEVEL_LIMITER_CLIP_COUNT_EN
      step(1'b1, DW'(40000));
      clr = 1'b1;
      step(1'b1, DW'(40000));
      clr = 1'b0;
      check("clear_priority", longint'(cnt), 0);
      step(1'b0, '0);
      #2 force dut.clip_count = 32'hFFFF_FFFF;
      #1 release dut.clip_count;
      m_cnt = CNT_MAX;
      step(1'b1, 24'h7FFFFF);
      check("count_saturate1", longint'(cnt), CNT_MAX);
      step(1'b1, 24'h800000);
      check("count_saturate2", longint'(cnt), CNT_MAX);
`endif

      for (int k = 0; k < 3000; k++) begin
         int mode;
         int val;
         mode = int'($urandom_range(0, 3));
         case (mode)
            0:       val = int'($urandom);
            1:       val = MAXI + int'($urandom_range(0, 4)) - 2;
            2:       val = MINI + int'($urandom_range(0, 4)) - 2;
            default: val = int'($urandom_range(0, 200)) - 100;
         endcase
`ifdef LEVEL_LIMITER_CLIP_COUNT_EN
         clr = ($urandom_range(0, 49) == 0);
`endif
         step($urandom_range(0, 3) != 0, DW'(val));
      end
`ifdef LEVEL_LIMITER_CLIP_COUNT_EN
      clr = 1'b0;
`endif
      step(1'b0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/level_limiter.md
Name: level_limiter

Overview:
- Registered signed saturator for the DSP datapath.
- Clamps each valid DATA_WIDTH-bit two's-complement sample to the range representable in LIMIT_NUMBER_OF_BITS signed bits.
- Returns the result sign-extended to DATA_WIDTH, with per-sample clip flags.
- Sits between gain/filter stages and narrower downstream consumers (DAC/packer), so later truncation to LIMIT_NUMBER_OF_BITS can never wrap.

Parameters:
- DATA_WIDTH, 24, width of input and output samples (signed); legal range 2..32.
- LIMIT_NUMBER_OF_BITS, 16, signed width the output is limited to; legal range 2..DATA_WIDTH. Elaboration error if out of range.

Ports:
- i_clk  input  1  sole clock, rising-edge.
- i_reset  input  1  asynchronous, active-high reset.
- iS_data  input  DATA_WIDTH  signed input sample.
- i_valid  input  1  iS_data qualifier; sampled each rising edge.
- oS_data  output  DATA_WIDTH  signed limited sample, sign-extended from LIMIT_NUMBER_OF_BITS.
- o_valid  output  1  oS_data qualifier.
- o_clip_pos  output  1  current output sample was clamped to MAX.
- o_clip_neg  output  1  current output sample was clamped to MIN.

Behaviour:
- MAX = 2^(LIMIT_NUMBER_OF_BITS-1)-1 and MIN = -2^(LIMIT_NUMBER_OF_BITS-1), both expressed at DATA_WIDTH.
- All outputs are registered. Latency is exactly 1 cycle from the i_valid edge to o_valid.
- i_valid=1 at a rising edge:
  - iS_data > MAX: oS_data<=MAX, o_clip_pos<=1, o_clip_neg<=0.
  - iS_data < MIN: oS_data<=MIN, o_clip_neg<=1, o_clip_pos<=0.
  - Otherwise: oS_data<=iS_data, both flags <=0.
  - o_valid<=1.
- i_valid=0 at a rising edge: o_valid<=0. oS_data and the clip flags hold their last values.
- No backpressure. One sample per cycle is accepted at full rate.
- Range detection: the input is in range iff bits [DATA_WIDTH-1 : LIMIT_NUMBER_OF_BITS-1] are all equal. If they are not, the MSB selects MAX (MSB=0) or MIN (MSB=1). No subtraction or comparator chain is used.
- LIMIT_NUMBER_OF_BITS==DATA_WIDTH: pure 1-cycle register. Clip flags are constant 0.
- o_clip_pos and o_clip_neg are never both 1.
- i_reset asserted (any time, including mid-stream): oS_data=0, o_valid=0, o_clip_pos=0, o_clip_neg=0 immediately, without waiting for a clock edge. A sample presented in the cycle reset is released is accepted normally.

Optional Feature:
- Macro LEVEL_LIMITER_CLIP_COUNT_EN.
- Defined: adds the following ports:
  - input i_clip_count_clear (1 bit, synchronous).
  - output o_clip_count (32 bits, unsigned).
- Counter behaviour when defined:
  - Increments by 1 on each accepted sample (i_valid=1) that is clamped.
  - Saturates at 2^32-1; never wraps.
  - i_clip_count_clear=1 sets the count to 0 at the next edge and has priority over an increment in the same cycle.
  - i_reset clears the count asynchronously.
- Undefined: the ports and counter do not exist. All other behaviour is identical.

Decomposition:
- Package level_limiter_pkg holds:
  - a function returning MAX/MIN for a given (data width, limit width);
  - localparam CLIP_COUNT_WIDTH=32.
- One natural combinational sub-module, level_limiter_sat. It takes the sample and produces the limited value plus pos/neg flags. level_limiter registers those outputs and holds the optional counter.

Test Plan (DATA_WIDTH=24, LIMIT_NUMBER_OF_BITS=16):
- Ramp from 0, i_valid=1, one increment per cycle:
  - 0..32767 appear unchanged 1 cycle later with no flags.
  - From 32768 upward, oS_data=32767 and o_clip_pos=1.
  - Counter (if enabled) increases by 1 per clipped sample.
- Boundary inputs 32767, 32768, -32768, -32769 produce 32767/no flag, 32767/pos, -32768/no flag, -32768/neg respectively.
- Full-scale inputs 8388607 (0x7FFFFF) and -8388608 (0x800000) produce 32767 (pos) and -32768 (neg); 0x00FFFF produces 32767 (pos).
- i_valid held low for 3 cycles after sample 100: o_valid=0 for those cycles and oS_data stays 100. The next valid sample 5 gives 5 one cycle later.
- i_reset pulsed asynchronously mid-ramp (between edges): all outputs, and the count if enabled, go to 0 before the next edge. The first valid sample after release appears 1 cycle later.
- LEVEL_LIMITER_CLIP_COUNT_EN defined:
  - Clear asserted in the same cycle as a clipped sample: count=0.
  - Count preset by forcing to 2^32-1, then another clip: count stays 2^32-1.
